// File: rtl/key_conditioner.sv
// Four-button front-end: synchronise the active-low keys, debounce them, and emit
// press/auto-repeat strobes, with pulses suppressed while an opposing pair is held.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 3000000,
    parameter int REPEAT_PERIOD   = 500000
) (
    input  logic       keyCLK,
    input  logic       reset,
    input  logic [3:0] keyRaw,
    output logic [3:0] key,
    output logic [3:0] keyPulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    logic [3:0]       sync_p0;
    logic [3:0]       sync_p1;
    logic [DB_W-1:0]  db_cnt [4];
    logic [3:0]       db_done;
    logic [3:0]       key_nxt;
    logic [3:0]       pair_mask;
    logic [3:0]       rpt_fire;
    rpt_state_t       rpt_state [4];
    logic [RPT_W-1:0] rpt_cnt [4];

    // Stage p0/p1: two-flop synchroniser, inverted so 1 means pressed
    always_ff @(posedge keyCLK) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= ~keyRaw;
            sync_p1 <= sync_p0;
        end
    end

    // The FSMs and the pair mask look at key_nxt so that a press pulse, a
    // suppressed repeat on release, and the mask all line up with the key edge.
    always_comb begin
        db_done = '0;
        for (int i = 0; i < 4; i++) begin
            db_done[i] = (sync_p1[i] != key[i]) && (db_cnt[i] == DB_LAST);
        end
        key_nxt   = key ^ db_done;
        pair_mask = {{2{key_nxt[3] & key_nxt[2]}}, {2{key_nxt[1] & key_nxt[0]}}};
    end

    // Stage debounce: accept a level only after DEBOUNCE_CYCLES stable samples
    always_ff @(posedge keyCLK) begin
        if (reset) begin
            key <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key <= key_nxt;
            for (int i = 0; i < 4; i++) begin
                if ((sync_p1[i] == key[i]) || db_done[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rpt_fire = '0;
        for (int i = 0; i < 4; i++) begin
            case (rpt_state[i])
                IDLE:    rpt_fire[i] = key_nxt[i] & ~key[i];
                DELAY:   rpt_fire[i] = key_nxt[i] && (rpt_cnt[i] == DELAY_LAST);
                REPEAT:  rpt_fire[i] = key_nxt[i] && (rpt_cnt[i] == PERIOD_LAST);
                default: rpt_fire[i] = 1'b0;
            endcase
        end
    end

    // Stage repeat: per-key IDLE/DELAY/REPEAT machines; mask applies only to the strobe
    always_ff @(posedge keyCLK) begin
        if (reset) begin
            keyPulse <= '0;
            for (int i = 0; i < 4; i++) begin
                rpt_state[i] <= IDLE;
                rpt_cnt[i]   <= '0;
            end
        end else begin
            keyPulse <= rpt_fire & ~pair_mask;
            for (int i = 0; i < 4; i++) begin
                case (rpt_state[i])
                    IDLE: begin
                        rpt_cnt[i] <= '0;
                        if (key_nxt[i] & ~key[i]) begin
                            rpt_state[i] <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (!key_nxt[i]) begin
                            rpt_state[i] <= IDLE;
                            rpt_cnt[i]   <= '0;
                        end else if (rpt_cnt[i] == DELAY_LAST) begin
                            rpt_state[i] <= REPEAT;
                            rpt_cnt[i]   <= '0;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!key_nxt[i]) begin
                            rpt_state[i] <= IDLE;
                            rpt_cnt[i]   <= '0;
                        end else if (rpt_cnt[i] == PERIOD_LAST) begin
                            rpt_cnt[i] <= '0;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        rpt_state[i] <= IDLE;
                        rpt_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected key/pulse events are queued by the
// stimulus and a negedge monitor pops one whenever the outputs change or pulse.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       keyCLK = 1'b0;
    logic       reset  = 1'b1;
    logic [3:0] keyRaw = 4'hF;
    logic [3:0] key;
    logic [3:0] keyPulse;

    key_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .keyCLK  (keyCLK),
        .reset   (reset),
        .keyRaw  (keyRaw),
        .key     (key),
        .keyPulse(keyPulse)
    );

    always #5 keyCLK = ~keyCLK;

    typedef struct packed {
        int         cyc;
        logic [3:0] key;
        logic [3:0] pulse;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;
    logic [3:0] last_key = 4'b0000;

    always @(posedge keyCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input logic [3:0] k, input logic [3:0] p);
        exp_t e;
        e.cyc   = c;
        e.key   = k;
        e.pulse = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge keyCLK);
    endtask

    // Monitor: any strobe or key change is an output event to be matched
    always @(negedge keyCLK) begin
        if (mon_en) begin
            if ((keyPulse != 4'b0000) || (key != last_key)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event at cycle %0d: key=%b pulse=%b, expected no event",
                             cyc, key, keyPulse);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_key", int'(key), int'(e.key));
                    check("event_pulse", int'(keyPulse), int'(e.pulse));
                end
            end
            last_key = key;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;

        // Reset held for three edges, then 20 idle cycles
        @(negedge keyCLK);
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge keyCLK);
            check("reset_key", int'(key), 0);
            check("reset_pulse", int'(keyPulse), 0);
        end
        reset = 1'b0;
        repeat (20) begin
            @(negedge keyCLK);
            check("post_reset_key", int'(key), 0);
            check("post_reset_pulse", int'(keyPulse), 0);
        end

        // Clean press and release on key 2
        c = cyc;
        push(c + 6,  4'b0100, 4'b0100);
        push(c + 16, 4'b0100, 4'b0100);
        push(c + 21, 4'b0100, 4'b0100);
        push(c + 26, 4'b0100, 4'b0100);
        push(c + 31, 4'b0100, 4'b0100);
        push(c + 36, 4'b0000, 4'b0000);
        keyRaw[2] = 1'b0;
        wait_to(c + 30);
        keyRaw[2] = 1'b1;
        wait_to(c + 44);
        check("pending_press_release", exp_q.size(), 0);

        // Bounce rejection on key 0
        c = cyc;
        t = c;
        for (int k = 0; k < 5; k++) begin
            keyRaw[0] = 1'b0;
            wait_to(t + 3);
            keyRaw[0] = 1'b1;
            wait_to(t + 4);
            t = t + 4;
        end
        check("bounce_key0", int'(key[0]), 0);
        push(t + 6,  4'b0001, 4'b0001);
        push(t + 14, 4'b0000, 4'b0000);
        keyRaw[0] = 1'b0;
        wait_to(t + 8);
        keyRaw[0] = 1'b1;
        wait_to(t + 20);
        check("pending_bounce", exp_q.size(), 0);

        // Opposing horizontal pair
        c = cyc;
        push(c + 6,  4'b1000, 4'b1000);
        push(c + 14, 4'b1100, 4'b0000);
        push(c + 54, 4'b1000, 4'b0000);
        push(c + 56, 4'b1000, 4'b1000);
        push(c + 61, 4'b1000, 4'b1000);
        push(c + 66, 4'b1000, 4'b1000);
        push(c + 68, 4'b0000, 4'b0000);
        keyRaw[3] = 1'b0;
        wait_to(c + 8);
        keyRaw[2] = 1'b0;
        wait_to(c + 30);
        check("pair_key_held", int'(key), 4'b1100);
        wait_to(c + 48);
        keyRaw[2] = 1'b1;
        wait_to(c + 62);
        keyRaw[3] = 1'b1;
        wait_to(c + 74);
        check("pending_pair", exp_q.size(), 0);

        // Release lands on the edge the first repeat is due, then a fresh press
        c = cyc;
        push(c + 6,  4'b0010, 4'b0010);
        push(c + 16, 4'b0000, 4'b0000);
        push(c + 26, 4'b0010, 4'b0010);
        push(c + 34, 4'b0000, 4'b0000);
        keyRaw[1] = 1'b0;
        wait_to(c + 10);
        keyRaw[1] = 1'b1;
        wait_to(c + 20);
        keyRaw[1] = 1'b0;
        wait_to(c + 28);
        keyRaw[1] = 1'b1;
        wait_to(c + 40);
        check("pending_race", exp_q.size(), 0);

        // Reset pulse while key 0 is auto-repeating
        c = cyc;
        push(c + 6,  4'b0001, 4'b0001);
        push(c + 16, 4'b0001, 4'b0001);
        push(c + 21, 4'b0001, 4'b0001);
        push(c + 24, 4'b0000, 4'b0000);
        push(c + 30, 4'b0001, 4'b0001);
        push(c + 38, 4'b0000, 4'b0000);
        keyRaw[0] = 1'b0;
        wait_to(c + 23);
        reset = 1'b1;
        wait_to(c + 24);
        reset = 1'b0;
        check("midhold_reset_key", int'(key), 0);
        wait_to(c + 32);
        keyRaw[0] = 1'b1;
        wait_to(c + 44);
        check("pending_midhold", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
